// File: rtl/sandbox_host_link.sv
// Host-side UART byte-stream bridge for the sandbox process: assembles 5-byte
// command frames into the command word and serializes 5-byte response frames.
module sandbox_host_link #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        rxValid,
  input  logic [7:0]  rxByte,
  input  logic        txBusy,
  output logic        txStart,
  output logic [7:0]  txByte,
  output logic        dataReceived,
  output logic [7:0]  control,
  output logic [31:0] inputData,
  input  logic        clearDR,
  input  logic        transmitData,
  input  logic [7:0]  status,
  input  logic [31:0] outputData,
  input  logic        clearErr,
  output logic [2:0]  errFlags
);

  localparam int TimerWidth = $clog2(TIMEOUT_CYCLES);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_COLLECT = 2'd1,
    RX_HOLD    = 2'd2,
    RX_WAIT    = 2'd3
  } rxState_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } txState_t;

  rxState_t              rxState;
  logic [2:0]            rxCount;
  logic [7:0]            controlShadow;
  logic [23:0]           dataShadow;
  logic [TimerWidth-1:0] rxTimer;

  txState_t              txState;
  logic [39:0]           txShift;
  logic [2:0]            txSent;
  logic                  transmitPrev;

  logic                  txRise;
  logic [2:0]            errSet;

  // Error set conditions and transmit-request edge detect
  always_comb begin
    txRise    = transmitData & ~transmitPrev;
    errSet[0] = rxValid & ((rxState == RX_HOLD) | (rxState == RX_WAIT));
    errSet[1] = (rxState == RX_COLLECT) & ~rxValid & (rxTimer == TimerLast);
    errSet[2] = txRise & (txState != TX_IDLE);
  end

  // Receive FSM: frame assembly, command hold and acknowledge handshake
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      rxState       <= RX_IDLE;
      rxCount       <= 3'd0;
      controlShadow <= 8'h00;
      dataShadow    <= 24'h000000;
      rxTimer       <= '0;
      dataReceived  <= 1'b0;
      control       <= 8'h00;
      inputData     <= 32'h00000000;
    end else begin
      case (rxState)
        RX_IDLE: begin
          if (rxValid) begin
            controlShadow <= rxByte;
            rxCount       <= 3'd1;
            rxTimer       <= '0;
            rxState       <= RX_COLLECT;
          end
        end
        RX_COLLECT: begin
          if (rxValid) begin
            rxTimer <= '0;
            if (rxCount == 3'd4) begin
              control      <= controlShadow;
              inputData    <= {dataShadow, rxByte};
              dataReceived <= 1'b1;
              rxState      <= RX_HOLD;
            end else begin
              dataShadow <= {dataShadow[15:0], rxByte};
              rxCount    <= rxCount + 3'd1;
            end
          end else if (errSet[1]) begin
            // Stale partial frame: the next byte starts a new frame
            rxState <= RX_IDLE;
          end else begin
            rxTimer <= rxTimer + TimerWidth'(1);
          end
        end
        RX_HOLD: begin
          if (clearDR) begin
            dataReceived <= 1'b0;
            rxState      <= RX_WAIT;
          end
        end
        RX_WAIT: begin
          if (!clearDR) begin
            rxState <= RX_IDLE;
          end
        end
        default: begin
          rxState <= RX_IDLE;
        end
      endcase
    end
  end

  // Transmit FSM: latch response on request edge and pace bytes out
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      txState      <= TX_IDLE;
      txShift      <= 40'h0000000000;
      txSent       <= 3'd0;
      transmitPrev <= 1'b0;
      txStart      <= 1'b0;
      txByte       <= 8'h00;
    end else begin
      transmitPrev <= transmitData;
      txStart      <= 1'b0;
      case (txState)
        TX_IDLE: begin
          if (txRise) begin
            txShift <= {status, outputData};
            txSent  <= 3'd0;
            txState <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (!txBusy) begin
            txStart <= 1'b1;
            txByte  <= txShift[39:32];
            txShift <= {txShift[31:0], 8'h00};
            txSent  <= txSent + 3'd1;
            txState <= TX_GAP;
          end
        end
        TX_GAP: begin
          // Gap cycle gives the transmitter time to raise txBusy
          txState <= (txSent < 3'd5) ? TX_SEND : TX_IDLE;
        end
        default: begin
          txState <= TX_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new set condition overrides a same-cycle clear
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      errFlags <= 3'b000;
    end else if (clearErr) begin
      errFlags <= errSet;
    end else begin
      errFlags <= errFlags | errSet;
    end
  end

endmodule

// File: tb/tb_sandbox_host_link.sv
// Self-checking bench for sandbox_host_link: directed scenarios plus randomized
// traffic checked every cycle against a frame-level reference model.
module tb_sandbox_host_link;

  localparam int TO = 16;

  logic        masterClock = 1'b0;
  logic        reset;
  logic        rxValid;
  logic [7:0]  rxByte;
  logic        txBusy;
  logic        txStart;
  logic [7:0]  txByte;
  logic        dataReceived;
  logic [7:0]  control;
  logic [31:0] inputData;
  logic        clearDR;
  logic        transmitData;
  logic [7:0]  status;
  logic [31:0] outputData;
  logic        clearErr;
  logic [2:0]  errFlags;

  sandbox_host_link #(.TIMEOUT_CYCLES(TO)) dut (
    .masterClock(masterClock), .reset(reset),
    .rxValid(rxValid), .rxByte(rxByte),
    .txBusy(txBusy), .txStart(txStart), .txByte(txByte),
    .dataReceived(dataReceived), .control(control), .inputData(inputData),
    .clearDR(clearDR), .transmitData(transmitData),
    .status(status), .outputData(outputData),
    .clearErr(clearErr), .errFlags(errFlags)
  );

  always #5 masterClock = ~masterClock;

  int checks = 0;
  int passes = 0;
  int pulseCount = 0;

  task automatic checkValue(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // UART transmitter stand-in: busy for busyLen cycles after each txStart
  int busyLen = 3;
  int busyLeft = 0;
  always @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      busyLeft <= 0;
      txBusy   <= 1'b0;
    end else if (txStart) begin
      busyLeft <= busyLen - 1;
      txBusy   <= 1'b1;
    end else if (busyLeft > 0) begin
      busyLeft <= busyLeft - 1;
      txBusy   <= 1'b1;
    end else begin
      txBusy   <= 1'b0;
    end
  end

  // Reference model: partial frame as a byte queue, response as a byte queue
  logic [7:0]  mFrame[$];
  logic [7:0]  mTxQ[$];
  bit          mHold, mWait, mTxActive, mTxGap;
  int          mQuiet;
  logic [7:0]  mCtrl, mTxByte;
  logic [31:0] mData;
  logic [2:0]  mFlags;
  logic        mTxStart, mPrevTd;

  function automatic void modelReset();
    mFrame.delete(); mTxQ.delete();
    mHold = 0; mWait = 0; mTxActive = 0; mTxGap = 0; mQuiet = 0;
    mCtrl = 8'h00; mData = 32'h0; mFlags = 3'b000;
    mTxStart = 1'b0; mTxByte = 8'h00; mPrevTd = 1'b0;
  endfunction

  function automatic void modelStep(input logic busy);
    logic [2:0] setBits;
    logic rise;
    setBits = 3'b000;
    if (mHold) begin
      if (rxValid) setBits[0] = 1'b1;
      if (clearDR) begin mHold = 0; mWait = 1; end
    end else if (mWait) begin
      if (rxValid) setBits[0] = 1'b1;
      if (!clearDR) mWait = 0;
    end else if (rxValid) begin
      mFrame.push_back(rxByte);
      mQuiet = 0;
      if (mFrame.size() == 5) begin
        mCtrl = mFrame[0];
        mData = {mFrame[1], mFrame[2], mFrame[3], mFrame[4]};
        mHold = 1;
        mFrame.delete();
      end
    end else if (mFrame.size() > 0) begin
      mQuiet++;
      if (mQuiet == TO) begin
        mFrame.delete();
        setBits[1] = 1'b1;
      end
    end
    rise = transmitData & ~mPrevTd;
    mPrevTd = transmitData;
    mTxStart = 1'b0;
    if (!mTxActive) begin
      if (rise) begin
        mTxActive = 1; mTxGap = 0;
        mTxQ = '{status, outputData[31:24], outputData[23:16], outputData[15:8], outputData[7:0]};
      end
    end else begin
      if (rise) setBits[2] = 1'b1;
      if (mTxGap) begin
        mTxGap = 0;
        if (mTxQ.size() == 0) mTxActive = 0;
      end else if (!busy) begin
        mTxStart = 1'b1;
        mTxByte = mTxQ.pop_front();
        mTxGap = 1;
      end
    end
    mFlags = clearErr ? setBits : (mFlags | setBits);
  endfunction

  task automatic compareAll();
    checkValue("dataReceived", 40'(dataReceived), 40'(mHold));
    checkValue("control", 40'(control), 40'(mCtrl));
    checkValue("inputData", 40'(inputData), 40'(mData));
    checkValue("errFlags", 40'(errFlags), 40'(mFlags));
    checkValue("txStart", 40'(txStart), 40'(mTxStart));
    checkValue("txByte", 40'(txByte), 40'(mTxByte));
  endtask

  // One clock: model consumes the inputs the DUT samples at this edge
  task automatic tick();
    if (reset) modelStep(txBusy);
    else modelReset();
    @(posedge masterClock);
    @(negedge masterClock);
    if (txStart) pulseCount++;
    compareAll();
  endtask

  task automatic sendByte(input logic [7:0] b);
    rxValid = 1'b1; rxByte = b;
    tick();
    rxValid = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic ackCommand();
    clearDR = 1'b1; tick();
    checkValue("ackDrop", 40'(dataReceived), 40'(0));
    clearDR = 1'b0; tick();
  endtask

  initial begin
    reset = 1'b0; rxValid = 1'b0; rxByte = 8'h00; clearDR = 1'b0;
    transmitData = 1'b0; status = 8'h00; outputData = 32'h0; clearErr = 1'b0;
    modelReset();
    repeat (2) @(negedge masterClock);
    compareAll();
    reset = 1'b1;
    tick();

    // Command frame, then overrun and clear
    sendByte(8'h03); sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
    checkValue("cmdCtrl", 40'(control), 40'(8'h03));
    checkValue("cmdData", 40'(inputData), 40'(32'h11223344));
    sendByte(8'h55);
    checkValue("overrunFlag", 40'(errFlags), 40'(3'b001));
    checkValue("overrunData", 40'(inputData), 40'(32'h11223344));
    clearErr = 1'b1; tick(); clearErr = 1'b0; tick();
    checkValue("clearErr", 40'(errFlags), 40'(3'b000));
    ackCommand();
    checkValue("holdCtrl", 40'(control), 40'(8'h03));
    checkValue("holdData", 40'(inputData), 40'(32'h11223344));

    // Response frame
    status = 8'h01; outputData = 32'hAB000000; busyLen = 3;
    pulseCount = 0;
    transmitData = 1'b1;
    idle(40);
    checkValue("respPulses", 40'(pulseCount), 40'(5));
    transmitData = 1'b0; tick();

    // Dropped request during the third response byte
    status = 8'h5C; outputData = 32'h01020304;
    pulseCount = 0;
    transmitData = 1'b1;
    for (int i = 0; i < 60 && mTxQ.size() != 2; i++) tick();
    checkValue("thirdByteReached", 40'(mTxQ.size()), 40'(2));
    transmitData = 1'b0; tick();
    transmitData = 1'b1; tick();
    idle(30);
    checkValue("dropFlag", 40'(errFlags[2]), 40'(1));
    checkValue("dropPulses", 40'(pulseCount), 40'(5));
    transmitData = 1'b0; clearErr = 1'b1; tick(); clearErr = 1'b0; tick();

    // Inter-byte timeout then a clean frame
    sendByte(8'hAA); sendByte(8'hBB);
    idle(TO + 2);
    checkValue("timeoutFlag", 40'(errFlags[1]), 40'(1));
    sendByte(8'h01); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h07);
    checkValue("afterTimeoutCtrl", 40'(control), 40'(8'h01));
    checkValue("afterTimeoutData", 40'(inputData), 40'(32'h00000007));
    ackCommand();
    clearErr = 1'b1; tick(); clearErr = 1'b0; tick();

    // Reset mid-operation (RX byte 3, TX byte 2); request stays high
    status = 8'h77; outputData = 32'h8899AABB;
    transmitData = 1'b1;
    sendByte(8'h10); sendByte(8'h20);
    for (int i = 0; i < 40 && mTxQ.size() != 3; i++) tick();
    rxValid = 1'b1; rxByte = 8'h30;
    reset = 1'b0;
    #1;
    checkValue("rstTxStart", 40'(txStart), 40'(0));
    checkValue("rstTxByte", 40'(txByte), 40'(0));
    checkValue("rstDR", 40'(dataReceived), 40'(0));
    checkValue("rstCtrl", 40'(control), 40'(0));
    checkValue("rstData", 40'(inputData), 40'(0));
    checkValue("rstErr", 40'(errFlags), 40'(0));
    rxValid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    pulseCount = 0;
    sendByte(8'h5A); sendByte(8'hDE); sendByte(8'hAD); sendByte(8'hBE); sendByte(8'hEF);
    checkValue("freshCtrl", 40'(control), 40'(8'h5A));
    checkValue("freshData", 40'(inputData), 40'(32'hDEADBEEF));
    idle(30);
    checkValue("freshPulses", 40'(pulseCount), 40'(5));
    ackCommand();
    transmitData = 1'b0; tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ((i % 300) == 0) busyLen = $urandom_range(1, 4);
      rxValid = (((i / 250) % 3) == 2) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
      rxByte = 8'($urandom);
      clearDR = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) transmitData = ~transmitData;
      status = 8'($urandom);
      outputData = $urandom;
      clearErr = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sandbox_host_link.md
# sandbox_host_link

Host-side byte-stream bridge for the sandbox process. Assembles 5-byte command frames from the UART receiver into the sandbox command word (`dataReceived`/`control`/`inputData`) and holds it until the process acknowledges with `clearDR`. Serializes the process result (`status`/`outputData`) back to the UART transmitter as a 5-byte response frame whenever the process raises `transmitData`. Sits between the UART byte interfaces and the sandbox process, on the same clock as the process.

## Interface
- `TIMEOUT_CYCLES`, 1000000: inter-byte timeout within a partial command frame, in clock cycles; must be at least 2.
- `masterClock`  in  1  operating clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rxValid`  in  1  one-cycle pulse: `rxByte` is valid.
- `rxByte`  in  8  received byte from the UART receiver.
- `txBusy`  in  1  high while the UART transmitter is sending.
- `txStart`  out  1  one-cycle pulse: start sending `txByte`.
- `txByte`  out  8  byte to transmit; stable from `txStart` until the next `txStart`.
- `dataReceived`  out  1  command word valid, held until acknowledged.
- `control`  out  8  command control byte.
- `inputData`  out  32  command data word.
- `clearDR`  in  1  process acknowledge; the process drops it only after `dataReceived` falls.
- `transmitData`  in  1  level request from the process; its rising edge starts a response.
- `status`  in  8  process status byte.
- `outputData`  in  32  process result word.
- `clearErr`  in  1  synchronous clear of `errFlags`.
- `errFlags`  out  3  sticky error flags:
  - [0] RX overrun
  - [1] frame timeout
  - [2] TX request dropped

## Operation
- **Frame format (both directions):** byte 0 is control or status. Bytes 1–4 are the data word, MSB first: byte 1 maps to [31:24] and byte 4 maps to [7:0].
- **RX FSM states:**
  - `RX_IDLE`: a byte arriving on `rxValid` loads the control shadow register, sets `cnt=1` and moves to `RX_COLLECT`.
  - `RX_COLLECT`: each `rxValid` shifts `rxByte` into the data shadow register and increments `cnt`. On the byte where `cnt==4`:
    - copy the shadow registers to `control`/`inputData`;
    - set `dataReceived=1`;
    - move to `RX_HOLD`.
  - `RX_HOLD`: when `clearDR` is sampled 1, set `dataReceived=0` and move to `RX_WAIT`.
  - `RX_WAIT`: when `clearDR` is sampled 0, move to `RX_IDLE`.
- **Output stability:** `control`/`inputData` change only on the frame-completion edge and keep their value after `dataReceived` falls.
- **RX overrun:** any `rxValid` in `RX_HOLD` or `RX_WAIT` drops the byte and sets `errFlags[0]`.
- **Timeout:** in `RX_COLLECT` the counter resets on each accepted byte. When it reaches `TIMEOUT_CYCLES-1` with no `rxValid`:
  - discard the partial frame;
  - set `errFlags[1]`;
  - return to `RX_IDLE`.
  - If `rxValid` arrives in the expiry cycle, the byte is accepted and the timeout does not fire.
- **Rising-edge detect:** `transmitData` is registered each cycle; a rising edge is current=1 and previous=0.
- **TX FSM states:**
  - `TX_IDLE`: on a rising edge, latch {`status`, `outputData`} into a 40-bit shift register, set `n=0` and move to `TX_SEND`.
  - `TX_SEND`: when `txBusy==0`:
    - drive `txStart=1` for one cycle;
    - put shift-register bits [39:32] on `txByte`;
    - shift left 8 bits;
    - increment `n`;
    - move to `TX_GAP`.
  - `TX_GAP`: one cycle, ignoring `txBusy`. Then go to `TX_SEND` if `n<5`, else to `TX_IDLE`.
- **TX request dropped:** a `transmitData` rising edge outside `TX_IDLE` is ignored and sets `errFlags[2]`.
- **Independence:** RX and TX FSMs run independently; simultaneous RX and TX activity is legal.
- **errFlags:** set conditions OR into the flags. `clearErr` clears them. If a set and `clearErr` occur in the same cycle, the set wins.
- **Reset:** asserting `reset` at any time:
  - forces both FSMs to idle;
  - drives all outputs to 0 (`txStart`, `txByte`, `dataReceived`, `control`, `inputData`, `errFlags`);
  - discards the partial frame and aborts the response.
  - The registered `transmitData` value resets to 0, so a request still high after reset release starts a fresh response.

## Timing
- Frame completion: 5th `rxValid` sampled at edge N gives `dataReceived=1` and new `control`/`inputData` visible after edge N.
- Acknowledge: `clearDR` sampled 1 at edge M gives `dataReceived=0` after edge M.
- The earliest next frame byte is accepted at the edge after `clearDR` is sampled 0.
- Response start: rising edge of `transmitData` sampled at edge T; the first `txStart` is high during the cycle after edge T+1, provided `txBusy=0`.
- Minimum spacing of `txStart` pulses is 2 cycles; the transmitter must raise `txBusy` within 1 cycle of `txStart`.
- Timeout fires exactly `TIMEOUT_CYCLES` cycles after the last accepted byte.

## Test plan
- **Command frame:** bytes 0x03,0x11,0x22,0x33,0x44 with `clearDR` held low → `dataReceived=1`, `control=0x03`, `inputData=0x11223344`. Then `clearDR=1` → `dataReceived=0` on the next cycle; `control`/`inputData` unchanged.
- **Response frame:** `status=0x01`, `outputData=0xAB000000`, `transmitData` rises, `txBusy` modelled at 3 cycles per byte → `txStart` pulses carry 0x01,0xAB,0x00,0x00,0x00 in order; no sixth pulse while `transmitData` stays high.
- **Timeout:** `TIMEOUT_CYCLES=16`, send 2 bytes then idle → `errFlags[1]=1` 16 cycles after the 2nd byte. The next 5 bytes 0x01,0,0,0,0x07 → `control=0x01`, `inputData=0x00000007`.
- **Overrun:** send a 6th byte while `dataReceived=1` → byte dropped, `errFlags[0]=1`, `inputData` unchanged. Then `clearErr` → `errFlags=0`.
- **Dropped request:** pulse `transmitData` low then high during the 3rd response byte → `errFlags[2]=1`; the original 5-byte response completes unaltered.
- **Reset mid-operation:** assert `reset` during the 3rd RX byte and the 2nd TX byte → all outputs 0 immediately. After release, a fresh 5-byte frame is decoded correctly with no leftover bytes.
